mmio_bridge_intc: RTL

// - Parametrised successor to the fixed-map CPU/peripheral bridge: decodes CPU data-port accesses onto N memory-mapped slaves

---
 rtl/mmio_pkg.sv | 44 ++++
 rtl/intc_core.sv | 78 +++++++
 rtl/mmio_bridge_intc.sv | 98 +++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the CPU-to-peripheral MMIO bridge: INTC register offsets,
// read-path hit classification and the default board address map.
package mmio_pkg;

  localparam int INTC_WIN_BYTES = 16;

  // Word offsets (address bits [3:2]) inside the INTC window.
  localparam logic [1:0] INTC_OFF_IMR  = 2'd0;
  localparam logic [1:0] INTC_OFF_PEND = 2'd1;
  localparam logic [1:0] INTC_OFF_MODE = 2'd2;
  localparam logic [1:0] INTC_OFF_RAW  = 2'd3;

  typedef enum logic [1:0] {
    HIT_NONE = 2'd0,
    HIT_SLV  = 2'd1,
    HIT_INTC = 2'd2
  } hit_kind_e;

  localparam logic [31:0] DM_BASE   = 32'h0000_0000;
  localparam logic [31:0] DM_MASK   = 32'hFFFF_C000;
  localparam logic [31:0] TC_BASE   = 32'h0000_7F00;
  localparam logic [31:0] TC_MASK   = 32'hFFFF_FFF0;
  localparam logic [31:0] UART_BASE = 32'h0000_7F10;
  localparam logic [31:0] UART_MASK = 32'hFFFF_FFF0;
  localparam logic [31:0] DT_BASE   = 32'h0000_7F20;
  localparam logic [31:0] DT_MASK   = 32'hFFFF_FFF0;
  localparam logic [31:0] LED_BASE  = 32'h0000_7F30;
  localparam logic [31:0] LED_MASK  = 32'hFFFF_FFF0;
  localparam logic [31:0] SW_BASE   = 32'h0000_7F40;
  localparam logic [31:0] SW_MASK   = 32'hFFFF_FFF0;
  localparam logic [31:0] KEY_BASE  = 32'h0000_7F50;
  localparam logic [31:0] KEY_MASK  = 32'hFFFF_FFF0;

  localparam int BOARD_N_SLAVES = 7;
  localparam logic [BOARD_N_SLAVES*32-1:0] BOARD_BASE =
    {KEY_BASE, SW_BASE, LED_BASE, DT_BASE, UART_BASE, TC_BASE, DM_BASE};
  localparam logic [BOARD_N_SLAVES*32-1:0] BOARD_MASK =
    {KEY_MASK, SW_MASK, LED_MASK, DT_MASK, UART_MASK, TC_MASK, DM_MASK};

  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/intc_core.sv
// Interrupt controller: source synchronisers, IMR/PEND/MODE registers and the
// registered masked interrupt vector driven to the CPU.
module intc_core
  import mmio_pkg::*;
#(
  parameter int N_IRQ = 6
) (
  input  logic             clk,
  input  logic             sys_rstn,
  input  logic [N_IRQ-1:0] irq_src,
  input  logic             wr_en,
  input  logic [1:0]       off,
  input  logic [3:0]       byteen,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [N_IRQ-1:0] hw_int
);

  logic [N_IRQ-1:0] sync1, sync2, sync3;
  logic [N_IRQ-1:0] imr, pend, mode;
  logic [N_IRQ-1:0] imr_next, pend_next, mode_next, clr, rise;
  logic [31:0]      lane_mask, wbits;
  logic             unused_lanes;

  assign lane_mask    = byte_mask(byteen);
  assign wbits        = wdata & lane_mask;
  assign unused_lanes = ^{lane_mask, wbits};
  assign rise         = sync2 & ~sync3;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    imr_next  = imr;
    mode_next = mode;
    clr       = '0;
    if (wr_en) begin
      case (off)
        INTC_OFF_IMR:  imr_next  = (imr & ~lane_mask[N_IRQ-1:0]) | wbits[N_IRQ-1:0];
        INTC_OFF_PEND: clr       = wbits[N_IRQ-1:0];
        INTC_OFF_MODE: mode_next = (mode & ~lane_mask[N_IRQ-1:0]) | wbits[N_IRQ-1:0];
        default:       ;
      endcase
    end
    // Edge bits: a new edge beats a same-cycle clear. Level bits just track the synced source.
    pend_next = (mode & ((pend & ~clr) | rise)) | (~mode & sync2);
  end

  always_comb begin
    rdata = '0;
    case (off)
      INTC_OFF_IMR:  rdata[N_IRQ-1:0] = imr;
      INTC_OFF_PEND: rdata[N_IRQ-1:0] = pend;
      INTC_OFF_MODE: rdata[N_IRQ-1:0] = mode;
      default:       rdata[N_IRQ-1:0] = sync2;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      sync1  <= '0;
      sync2  <= '0;
      sync3  <= '0;
      imr    <= '0;
      pend   <= '0;
      mode   <= '0;
      hw_int <= '0;
    end else begin
      // NOTE: non-blocking assignments so each flop samples the pre-edge value of its neighbour (a true shift chain).
      sync1  <= irq_src;
      sync2  <= sync1;
      sync3  <= sync2;
      imr    <= imr_next;
      mode   <= mode_next;
      pend   <= pend_next;
      hw_int <= pend & imr;
    end
  end

endmodule

// File: rtl/mmio_bridge_intc.sv
// CPU data-port bridge: base/mask window decode onto N slaves plus an internal
// interrupt controller, with a one-cycle registered read return path.
module mmio_bridge_intc
  import mmio_pkg::*;
#(
  parameter int                    N_SLAVES   = 8,
  parameter logic [N_SLAVES*32-1:0] SLAVE_BASE = {N_SLAVES{32'h0}},
  parameter logic [N_SLAVES*32-1:0] SLAVE_MASK = {N_SLAVES{32'h0}},
  parameter int                    N_IRQ      = 6,
  parameter logic [31:0]           INTC_BASE  = 32'h0000_7F80
) (
  input  logic                  clk,
  input  logic                  sys_rstn,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wdata,
  input  logic [3:0]            cpu_byteen,
  output logic [31:0]           cpu_rdata,
  output logic                  bus_err,
  output logic [31:0]           slv_addr,
  output logic [31:0]           slv_wdata,
  output logic [4*N_SLAVES-1:0] slv_byteen,
  output logic [N_SLAVES-1:0]   slv_sel,
  input  logic [32*N_SLAVES-1:0] slv_rdata,
  input  logic [N_IRQ-1:0]      irq_src,
  output logic [N_IRQ-1:0]      hw_int
);

  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  hit_kind_e        kind, kind_q;
  logic [IDX_W-1:0] hit_idx, idx_q;
  logic             slv_hit, intc_hit, intc_wr, err_q;
  logic [31:0]      intc_rdata, intc_q;

  assign slv_addr  = cpu_addr;
  assign slv_wdata = cpu_wdata;
  assign intc_hit  = (cpu_addr[31:4] == INTC_BASE[31:4]);
  assign intc_wr   = (kind == HIT_INTC) && (cpu_byteen != 4'h0);
  assign bus_err   = err_q;

  // Walk from the top index down so the lowest-index matching window is the one kept.
  always_comb begin
    slv_hit = 1'b0;
    hit_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (((cpu_addr ^ SLAVE_BASE[32*i +: 32]) & SLAVE_MASK[32*i +: 32]) == 32'h0) begin
        slv_hit = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
    kind = intc_hit ? HIT_INTC : (slv_hit ? HIT_SLV : HIT_NONE);
  end

  always_comb begin
    slv_sel    = '0;
    slv_byteen = '0;
    if (kind == HIT_SLV) slv_sel[hit_idx] = 1'b1;
    for (int i = 0; i < N_SLAVES; i++) begin
      slv_byteen[4*i +: 4] = slv_sel[i] ? cpu_byteen : 4'h0;
    end
  end

  intc_core #(.N_IRQ(N_IRQ)) u_intc (
    .clk      (clk),
    .sys_rstn (sys_rstn),
    .irq_src  (irq_src),
    .wr_en    (intc_wr),
    .off      (cpu_addr[3:2]),
    .byteen   (cpu_byteen),
    .wdata    (cpu_wdata),
    .rdata    (intc_rdata),
    .hw_int   (hw_int)
  );

  // INTC data is captured at the access edge so a same-cycle write is not visible in the read.
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      kind_q <= HIT_NONE;
      idx_q  <= '0;
      intc_q <= '0;
      err_q  <= 1'b0;
    end else begin
      kind_q <= kind;
      idx_q  <= hit_idx;
      intc_q <= intc_rdata;
      err_q  <= (kind == HIT_NONE);
    end
  end

  always_comb begin
    case (kind_q)
      HIT_SLV:  cpu_rdata = slv_rdata[{idx_q, 5'b0} +: 32];
      HIT_INTC: cpu_rdata = intc_q;
      default:  cpu_rdata = 32'h0;
    endcase
  end

endmodule
